// File: rtl/mem_bus_arbiter.sv
// Round-robin merge of the instruction and data ports of the core onto one
// single-ported memory bus, with a response watchdog that forces completion.
module mem_bus_arbiter #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      imem_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] imem_addr_i,
    output logic [MEM_DATA_WIDTH-1:0] imem_rdata_o,
    output logic                      imem_ack_o,
    input  logic                      dmem_req_i,
    input  logic                      dmem_we_i,
    input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                      dmem_ack_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [MEM_DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                      mem_ack_i,
    output logic                      err_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        last_d_q, last_d_d;  // 1 = last grant went to dmem
    logic                        req_q, req_d;
    logic                        we_q, we_d;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [MEM_DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic busy;
    logic timeout;
    logic done;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b1;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // A real ack always beats a coincident watchdog expiry.
    assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign timeout = WD_EN && busy && (cnt_q == CNT_MAX) && !mem_ack_i;
    assign done    = busy && (mem_ack_i || timeout);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (imem_req_i && (!dmem_req_i || last_d_q)) begin
                    state_d  = BUSY_I;
                    cnt_d    = '0;
                    last_d_d = 1'b0;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = imem_addr_i;
                    wdata_d  = '0;
                end else if (dmem_req_i) begin
                    state_d  = BUSY_D;
                    cnt_d    = '0;
                    last_d_d = 1'b1;
                    req_d    = 1'b1;
                    we_d     = dmem_we_i;
                    addr_d   = dmem_addr_i;
                    wdata_d  = dmem_wdata_i;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        imem_ack_o   = (state_q == BUSY_I) && done;
        dmem_ack_o   = (state_q == BUSY_D) && done;
        imem_rdata_o = ((state_q == BUSY_I) && mem_ack_i) ? mem_rdata_i : '0;
        dmem_rdata_o = ((state_q == BUSY_D) && mem_ack_i) ? mem_rdata_i : '0;
        err_o        = timeout;
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus watchdog
// and reset-during-transaction sequences.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        arst;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        iack;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dack;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [31:0] mrdata;
  logic        mack;
  logic        err;

  int n_checks = 0;
  int n_pass = 0;

  mem_bus_arbiter #(
    .MEM_ADDR_WIDTH(32),
    .MEM_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .arst_i(arst),
    .imem_req_i(ireq),
    .imem_addr_i(iaddr),
    .imem_rdata_o(irdata),
    .imem_ack_o(iack),
    .dmem_req_i(dreq),
    .dmem_we_i(dwe),
    .dmem_addr_i(daddr),
    .dmem_wdata_i(dwdata),
    .dmem_rdata_o(drdata),
    .dmem_ack_o(dack),
    .mem_req_o(mreq),
    .mem_we_o(mwe),
    .mem_addr_o(maddr),
    .mem_wdata_o(mwdata),
    .mem_rdata_i(mrdata),
    .mem_ack_i(mack),
    .err_o(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ireq;
    logic [31:0]  iaddr;
    logic         dreq;
    logic         dwe;
    logic [31:0]  daddr;
    logic [31:0]  dwdata;
    logic         mack;
    logic [31:0]  mrdata;
    logic [132:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [132:0] outs();
    return {mreq, mwe, maddr, mwdata, iack, irdata, dack, drdata, err};
  endfunction

  task automatic chk(input string name, input logic [132:0] got, input logic [132:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic add(
    input logic a_ireq, input logic [31:0] a_iaddr, input logic a_dreq, input logic a_dwe,
    input logic [31:0] a_daddr, input logic [31:0] a_dwdata, input logic a_mack, input logic [31:0] a_mrdata,
    input logic e_mreq, input logic e_mwe, input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
    input logic e_iack, input logic [31:0] e_irdata, input logic e_dack, input logic [31:0] e_drdata,
    input logic e_err);
    vec_t v;
    v.ireq = a_ireq; v.iaddr = a_iaddr; v.dreq = a_dreq; v.dwe = a_dwe;
    v.daddr = a_daddr; v.dwdata = a_dwdata; v.mack = a_mack; v.mrdata = a_mrdata;
    v.exp = {e_mreq, e_mwe, e_maddr, e_mwdata, e_iack, e_irdata, e_dack, e_drdata, e_err};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    ireq = v.ireq; iaddr = v.iaddr; dreq = v.dreq; dwe = v.dwe;
    daddr = v.daddr; dwdata = v.dwdata; mack = v.mack; mrdata = v.mrdata;
  endtask

  initial begin
    int n;
    bit seen;
    arst = 1'b0; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
    daddr = '0; dwdata = '0; mack = 1'b0; mrdata = '0;
    #1 arst = 1'b1;
    #1 chk("reset_state", outs(), 133'(0));

    // Both held from reset (imem first), then single imem with wait states,
    // zero-wait dmem write, then an ack landing exactly on the watchdog cycle.
    add(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b1, 32'h100,  1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b1, 32'h100,  1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h11111111, 1'b1, 1'b0, 32'h100,  32'h0, 1'b1, 32'h11111111, 1'b0, 32'h0,        1'b0);
    add(1'b1, 32'h100,  1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h00000BAD, 1'b0, 1'b0, 32'h100,  32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b1, 32'h100,  1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h22222222, 1'b1, 1'b0, 32'h200,  32'h0, 1'b0, 32'h0,        1'b1, 32'h22222222, 1'b0);
    add(1'b1, 32'h100,  1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h200,  32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b1, 32'h100,  1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h33333333, 1'b1, 1'b0, 32'h100,  32'h0, 1'b1, 32'h33333333, 1'b0, 32'h0,        1'b0);
    add(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100,  32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1000, 32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b0, 32'h0,    1'b1, 1'b1, 32'h20,  32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b0, 32'h0,    1'b1, 1'b1, 32'h20,  32'hA5A5A5A5, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1, 32'h12345678, 1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h20,   32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 32'h0,        1'b0);
    add(1'b0, 32'h0,    1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h20,   32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 32'h0,        1'b0);
    add(1'b0, 32'h0,    1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h200,  32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h200,  32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h200,  32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h200,  32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0, 1'b1, 32'h44444444, 1'b1, 1'b0, 32'h200,  32'h0, 1'b0, 32'h0,        1'b1, 32'h44444444, 1'b0);
    add(1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h200,  32'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0);

    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 chk($sformatf("row%0d", i), outs(), vecs[i].exp);
    end

    // Watchdog: memory never answers, forced completion on the 5th busy cycle.
    @(negedge clk);
    ireq = 1'b1; iaddr = 32'h300; mack = 1'b0; mrdata = 32'hFFFFFFFF;
    n = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (iack) begin
        seen = 1'b1;
        n = c;
        chk("wd_err", 133'(err), 133'(1));
        chk("wd_rdata", 133'(irdata), 133'(0));
      end else begin
        chk("wd_busy", 133'({mreq, maddr, err, dack}), 133'({1'b1, 32'h300, 1'b0, 1'b0}));
      end
    end
    chk("wd_cycle", 133'(n), 133'(5));
    ireq = 1'b0;
    @(negedge clk);
    mack = 1'b1; mrdata = 32'h77;
    #1 chk("late_ack", 133'({mreq, iack, dack, err, irdata}), 133'(0));
    @(negedge clk);
    mack = 1'b0;
    #1 chk("late_idle", 133'(mreq), 133'(0));

    // Reset while BUSY_D, then arbitration restarts with imem priority.
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h40; dwdata = 32'h55;
    @(negedge clk);
    #1 chk("rst_busy", 133'({mreq, mwe, maddr}), 133'({1'b1, 1'b1, 32'h40}));
    #1 arst = 1'b1;
    #1 chk("rst_async", 133'({mreq, mwe, maddr, mwdata}), 133'(0));
    mack = 1'b1; mrdata = 32'h99;
    #1 chk("rst_noack", 133'({dack, iack, err, drdata}), 133'(0));
    @(negedge clk);
    ireq = 1'b1; iaddr = 32'h500; mack = 1'b0;
    arst = 1'b0;
    @(negedge clk);
    #1 chk("rst_grant", 133'({mreq, mwe, maddr}), 133'({1'b1, 1'b0, 32'h500}));
    mack = 1'b1; mrdata = 32'hCAFE;
    #1 chk("rst_iack", 133'({iack, irdata, dack}), 133'({1'b1, 32'hCAFE, 1'b0}));
    @(negedge clk);
    ireq = 1'b0; dreq = 1'b0; mack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sits directly downstream of simple_processor.
- Merges its instruction port (imem_*) and data port (dmem_*) onto one shared memory port (mem_*) driving the single-ported system memory.
- Serves one request at a time, arbitrates round-robin on conflict, and returns ack/rdata to the granted requester.
- A response watchdog completes hung transactions with an error pulse so the core never deadlocks.

Parameters:
- MEM_ADDR_WIDTH, 32, width of all address buses
- MEM_DATA_WIDTH, 32, width of all data buses
- TIMEOUT_CYCLES, 255, extra busy cycles tolerated without mem_ack_i before forced completion; 0 disables the watchdog

Ports:
- clk_i  in  1  global synchronous clock
- arst_i  in  1  asynchronous reset, active-high
- imem_req_i  in  1  instruction request, held until imem_ack_o
- imem_addr_i  in  MEM_ADDR_WIDTH  instruction address
- imem_rdata_o  out  MEM_DATA_WIDTH  instruction read data, valid with imem_ack_o
- imem_ack_o  out  1  one-cycle completion pulse
- dmem_req_i  in  1  data request, held until dmem_ack_o
- dmem_we_i  in  1  1 = write, 0 = read
- dmem_addr_i  in  MEM_ADDR_WIDTH  data address
- dmem_wdata_i  in  MEM_DATA_WIDTH  write data
- dmem_rdata_o  out  MEM_DATA_WIDTH  data read data, valid with dmem_ack_o
- dmem_ack_o  out  1  one-cycle completion pulse
- mem_req_o  out  1  shared-port request (registered)
- mem_we_o  out  1  shared-port write enable (registered)
- mem_addr_o  out  MEM_ADDR_WIDTH  shared-port address (registered)
- mem_wdata_o  out  MEM_DATA_WIDTH  shared-port write data (registered)
- mem_rdata_i  in  MEM_DATA_WIDTH  shared-port read data
- mem_ack_i  in  1  shared-port completion
- err_o  out  1  pulses with the ack of a watchdog-terminated transaction

Behaviour:

Reset (arst_i high, async):
- state = IDLE; mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o = 0; counter = 0; last_grant = DMEM.
- All ack outputs and err_o = 0.
- rdata outputs = 0.
- Reset mid-transaction drops mem_req_o immediately; no ack is issued.

FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Only imem_req_i: go to BUSY_I.
  - Only dmem_req_i: go to BUSY_D.
  - Both: grant the port not equal to last_grant.
  - On grant, register addr/wdata/we (imem: we = 0, wdata = 0), set mem_req_o = 1, counter = 0, last_grant = granted port.
  - No request: stay in IDLE with mem_req_o = 0.
- BUSY_x:
  - mem_req_o and the registered address/data/we stay constant.
  - If mem_ack_i = 1: granted ack_o = 1 and granted rdata_o = mem_rdata_i, both combinational in the same cycle. Next edge: mem_req_o = 0, state = IDLE.
  - Otherwise the counter increments.
  - Timeout: if TIMEOUT_CYCLES ≠ 0, counter == TIMEOUT_CYCLES, and mem_ack_i = 0, then ack_o = 1, err_o = 1, rdata_o = 0 for the granted port. Next edge goes to IDLE.
  - mem_ack_i and timeout in the same cycle: the real ack wins and err_o = 0.

Output rules:
- Non-granted ack and rdata outputs are 0.
- mem_ack_i while IDLE is ignored; a late ack after a timeout produces no output.
- A requester dropping req mid-transaction does not abort it; ack is still pulsed.

Latency and throughput:
- Request seen in cycle 0 → mem_req_o high in cycle 1 → earliest ack in cycle 1.
- At least one IDLE cycle separates transactions, so back-to-back throughput is 1 per 2 cycles at best.
- Requests are sampled only in IDLE.

Widths:
- Counter is $clog2(TIMEOUT_CYCLES+1) bits, with a minimum of 1, and saturates at TIMEOUT_CYCLES.

Test Plan:
1. imem_req_i = 1, imem_addr_i = 0x1000; memory acks 2 cycles after mem_req_o with rdata = 0xDEADBEEF → mem_addr_o = 0x1000, mem_we_o = 0; imem_ack_o pulses once with imem_rdata_o = 0xDEADBEEF; dmem_ack_o stays 0.
2. dmem write, addr 0x20, wdata 0xA5A5A5A5, we = 1; zero-wait ack → mem_we_o = 1, mem_wdata_o = 0xA5A5A5A5, dmem_ack_o in cycle 1; mem_req_o low in cycle 2.
3. Both requests held continuously after reset, with immediate acks → grant order IMEM, DMEM, IMEM, DMEM; no starvation; one IDLE cycle between grants.
4. TIMEOUT_CYCLES = 4 and memory never acks → imem_ack_o = 1 and err_o = 1 with rdata 0 on the 5th busy cycle; a later mem_ack_i pulse is ignored.
5. mem_ack_i asserted exactly on the timeout cycle → ack with err_o = 0 and the real rdata.
6. arst_i pulsed while BUSY_D → mem_req_o = 0 asynchronously; no dmem_ack_o; after release with both requests high, IMEM is granted first.
